// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding cache request, single-entry output register, redirect with discard.
// Optional statistics counters are enabled by defining INSTRUCTION_FETCH_STATS_EN.
module instruction_fetch #(
  parameter int unsigned                 ADDRESS_BITWIDTH = 32,
  parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        ic_enable,
  output logic [ADDRESS_BITWIDTH-1:0] ic_address,
  input  logic [31:0]                 ic_data,
  input  logic                        ic_data_ready,
  input  logic                        ic_busy,
  input  logic                        redirect,
  input  logic [ADDRESS_BITWIDTH-1:0] redirect_pc,
  output logic [31:0]                 instr,
  output logic [ADDRESS_BITWIDTH-1:0] instr_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    ISSUE     = 2'd0,
    WAIT_DATA = 2'd1,
    WAIT_IDLE = 2'd2
  } state_e;

  localparam logic [ADDRESS_BITWIDTH-1:0] PC_STEP  = ADDRESS_BITWIDTH'(4);
  localparam logic [ADDRESS_BITWIDTH-1:0] PC_RESET = {RESET_PC[ADDRESS_BITWIDTH-1:2], 2'b00};

  state_e                      state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0] pc_q, pc_d;
  logic                        ic_enable_q, ic_enable_d;
  logic [ADDRESS_BITWIDTH-1:0] ic_address_q, ic_address_d;
  logic [31:0]                 instr_q, instr_d;
  logic [ADDRESS_BITWIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                        instr_valid_q, instr_valid_d;
  logic                        discard_q, discard_d;

  // Output handshake: instr/instr_pc are held while instr_valid=1 and are consumed
  // on any cycle with instr_valid & instr_ready; a capture in that cycle refills the slot.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ic_enable_d   = 1'b0;
    ic_address_d  = ic_address_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    discard_d     = discard_q;

    if (instr_valid_q && instr_ready) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      ISSUE: begin
        if (!redirect && !ic_busy && (!instr_valid_q || instr_ready)) begin
          ic_enable_d  = 1'b1;
          ic_address_d = pc_q;
          state_d      = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (ic_data_ready) begin
          // A pending or simultaneous redirect makes this response stale.
          if (!redirect && !discard_q) begin
            instr_d       = ic_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + PC_STEP;
          end
          discard_d = 1'b0;
          state_d   = ic_busy ? WAIT_IDLE : ISSUE;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!ic_busy) begin
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase

    if (redirect) begin
      pc_d          = {redirect_pc[ADDRESS_BITWIDTH-1:2], 2'b00};
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ISSUE;
      pc_q          <= PC_RESET;
      ic_enable_q   <= 1'b0;
      ic_address_q  <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ic_enable_q   <= ic_enable_d;
      ic_address_q  <= ic_address_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      discard_q     <= discard_d;
    end
  end

  assign ic_enable   = ic_enable_q;
  assign ic_address  = ic_address_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign dbg_state   = state_q;

`ifdef INSTRUCTION_FETCH_STATS_EN
  logic [31:0] stat_fetches_q, stat_fetches_d;
  logic [31:0] stat_discards_q, stat_discards_d;
  logic [31:0] stat_stall_cycles_q, stat_stall_cycles_d;
  logic        stat_capture, stat_drop, stat_stall;

  always_comb begin
    stat_capture        = (state_q == WAIT_DATA) && ic_data_ready && !redirect && !discard_q;
    stat_drop           = (state_q == WAIT_DATA) && ic_data_ready && (redirect || discard_q);
    stat_stall          = instr_valid_q && !instr_ready;
    stat_fetches_d      = stat_fetches_q + 32'(stat_capture);
    stat_discards_d     = stat_discards_q + 32'(stat_drop);
    stat_stall_cycles_d = stat_stall_cycles_q + 32'(stat_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetches_q      <= '0;
      stat_discards_q     <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      stat_fetches_q      <= stat_fetches_d;
      stat_discards_q     <= stat_discards_d;
      stat_stall_cycles_q <= stat_stall_cycles_d;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural cache with random latency/busy tail, program-order scoreboard.
module tb_instruction_fetch;
  localparam int AW = 32;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_enable;
  logic [AW-1:0] ic_address;
  logic [31:0]   ic_data;
  logic          ic_data_ready;
  logic          ic_busy;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    dbg_state;

  instruction_fetch #(.ADDRESS_BITWIDTH(AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .ic_enable(ic_enable), .ic_address(ic_address),
    .ic_data(ic_data), .ic_data_ready(ic_data_ready), .ic_busy(ic_busy),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  // Expected accepted stream: {pc, word} in program order from the last (re)start point.
  logic [2*AW-1:0] exp_q[$];
  logic [AW-1:0]   next_pc;
  logic [2*AW-1:0] exp_e;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    case (a)
      32'h0:   return 32'hB7C6A980;
      32'h4:   return 32'h3F5A2E14;
      32'h8:   return 32'hAB4C3E6F;
      default: return (a * 32'h9E3779B1) ^ 32'h5EED_1234;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [AW-1:0] a);
    exp_q.delete();
    next_pc = {a[AW-1:2], 2'b00};
    refill();
  endtask

  // ---------------- cache model ----------------
  logic          c_out, c_prev_en;
  logic [AW-1:0] c_addr, c_prev_addr;
  int            c_lat, c_tail;

  initial begin
    ic_busy = 1'b0; ic_data_ready = 1'b0; ic_data = '0;
    c_out = 1'b0; c_prev_en = 1'b0; c_prev_addr = '0; c_addr = '0; c_lat = 0; c_tail = 0;
    forever begin
      @(posedge clk); #1;
      ic_data_ready = 1'b0;
      ic_data = $urandom;
      if (rst) begin
        c_out = 1'b0; c_tail = 0; ic_busy = 1'b0;
      end else begin
        if (c_prev_en) begin
          check("one_outstanding", c_out, 1'b0);
          c_out  = 1'b1;
          c_lat  = $urandom_range(0, 3);
          c_addr = c_prev_addr;
        end
        if (c_out) begin
          if (c_lat == 0) begin
            ic_data_ready = 1'b1;
            ic_data       = mem_word(c_addr);
            c_out         = 1'b0;
            c_tail        = $urandom_range(0, 2);
            ic_busy       = (c_tail != 0);
            if (c_tail != 0) c_tail--;
          end else begin
            c_lat--;
            ic_busy = 1'b1;
          end
        end else if (c_tail != 0) begin
          ic_busy = 1'b1;
          c_tail--;
        end else begin
          ic_busy = 1'b0;
        end
      end
      c_prev_en   = ic_enable;
      c_prev_addr = ic_address;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (ic_enable) begin
        check("enable_while_busy", ic_busy, 1'b0);
        check("addr_align", ic_address[1:0], 2'b00);
      end
      if (instr_valid && instr_ready && !redirect) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL hs_unexpected: got pc 0x%0h, expected no handshake", instr_pc);
        end else begin
          exp_e = exp_q.pop_front();
          check("hs_pc", instr_pc, exp_e[2*AW-1:32]);
          check("hs_instr", instr, exp_e[31:0]);
          refill();
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk); #2;
  endtask

  task automatic wait_en(input string name, input int budget);
    int k;
    k = 0;
    while (!ic_enable && k < budget) begin cycle(); k++; end
    check(name, ic_enable, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ic_enable"}, ic_enable, 1'b0);
    check({tag, "_ic_address"}, ic_address, RESET_PC);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, 32'h0);
    check({tag, "_instr_valid"}, instr_valid, 1'b0);
  endtask

  logic          stall_ok;
  int            en_cnt, k;
  logic [31:0]   dis0;

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    restart(RESET_PC);
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");

    // Stall right after the first capture; only 0xB7C6A980 @ 0 may be presented.
    rst = 1'b0;
    k = 0;
    while (!instr_valid && k < 20) begin cycle(); k++; end
    check("first_capture_valid", instr_valid, 1'b1);
    stall_ok = 1'b1; en_cnt = 0;
    repeat (20) begin
      cycle();
      if (ic_enable) en_cnt++;
      if (instr !== 32'hB7C6A980 || instr_pc !== 32'h0 || !instr_valid) stall_ok = 1'b0;
    end
    check("stall_hold", stall_ok, 1'b1);
    check("stall_no_issue", en_cnt, 0);
    instr_ready = 1'b1;
    cycle();
    check("release_issue", ic_enable, 1'b1);
    check("release_addr", ic_address, 32'h4);
    repeat (40) cycle();
    check("stream_started", n_hs >= 3, 1'b1);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      cycle();
      redirect = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
        instr_ready = 1'b0;
        restart(redirect_pc);
      end else begin
        instr_ready = ($urandom_range(0, 3) != 0);
      end
    end
    cycle(); redirect = 1'b0; instr_ready = 1'b1;

    // Redirect to 0x43 while the request is in flight.
`ifdef INSTRUCTION_FETCH_STATS_EN
    dis0 = dut.stat_discards_q;
`else
    dis0 = '0;
`endif
    wait_en("wd_issue_seen", 40);
    redirect = 1'b1; redirect_pc = 32'h43; instr_ready = 1'b0; restart(32'h43);
    cycle(); redirect = 1'b0; instr_ready = 1'b1;
    wait_en("wd_reissue_seen", 40);
    check("wd_redirect_addr", ic_address, 32'h40);
`ifdef INSTRUCTION_FETCH_STATS_EN
    check("wd_stat_discards", dut.stat_discards_q - dis0, 32'd1);
`endif
    repeat (10) cycle();

    // Redirect coinciding with ic_data_ready.
    k = 0;
    while (!ic_data_ready && k < 40) begin cycle(); k++; end
    check("dr_ready_seen", ic_data_ready, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h1000; instr_ready = 1'b0; restart(32'h1000);
    cycle(); redirect = 1'b0; instr_ready = 1'b1;
    check("dr_no_valid", instr_valid, 1'b0);
    wait_en("dr_reissue_seen", 40);
    check("dr_redirect_addr", ic_address, 32'h1000);
    repeat (10) cycle();

    // pc wrap across the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; instr_ready = 1'b0; restart(32'hFFFF_FFF8);
    cycle(); redirect = 1'b0; instr_ready = 1'b1;
    wait_en("wrap_en0", 40);
    check("wrap_addr0", ic_address, 32'hFFFF_FFF8);
    cycle();
    wait_en("wrap_en1", 40);
    check("wrap_addr1", ic_address, 32'hFFFF_FFFC);
    cycle();
    wait_en("wrap_en2", 40);
    check("wrap_addr2", ic_address, 32'h0000_0000);
    repeat (10) cycle();

    // Reset while a request is outstanding.
    wait_en("rst_issue_seen", 40);
    rst = 1'b1; instr_ready = 1'b0; restart(RESET_PC);
    cycle();
    check_reset_outputs("midrst");
    rst = 1'b0; instr_ready = 1'b1;
    wait_en("rst_reissue_seen", 40);
    check("rst_restart_addr", ic_address, RESET_PC);
    repeat (40) cycle();

    check("handshake_volume", n_hs > 20, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
